// File: rtl/haar_diff_if.sv
// Pixel-pair stream interface for the Haar difference unit.
//   master : drives valid_in/a/b, observes out/valid_out/sample_cnt (and avg)
//   slave  : the haar_diff datapath
// Optional macro HAAR_AVG_EN adds the avg (approximation coefficient) signal.
interface haar_diff_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32
);
  logic              valid_in;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] out;
  logic              valid_out;
  logic [CNT_W-1:0]  sample_cnt;
`ifdef HAAR_AVG_EN
  logic [DATA_W-1:0] avg;

  modport master (output valid_in, a, b, input out, valid_out, sample_cnt, avg);
  modport slave  (input valid_in, a, b, output out, valid_out, sample_cnt, avg);
`else
  modport master (output valid_in, a, b, input out, valid_out, sample_cnt);
  modport slave  (input valid_in, a, b, output out, valid_out, sample_cnt);
`endif
endinterface

// File: rtl/haar_diff.sv
// Streaming 1-D Haar detail unit: out = ((a - b) >> 1) + 2^(DATA_W-1), offset binary.
// Two register stages, valid strobe travels with the data, no backpressure.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    haar_diff_if.slave: valid_in, a, b in; out, valid_out, sample_cnt out
// Optional macro HAAR_AVG_EN adds avg = (a + b) >> 1, aligned with out.
module haar_diff #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  haar_diff_if.slave   bus
);

  // Adding 2^DATA_W before the halving keeps the difference non-negative, so a
  // logical shift gives floor((a-b)/2) + 2^(DATA_W-1) directly.
  localparam logic [DATA_W:0] BIAS = {1'b1, {DATA_W{1'b0}}};

  logic              r_v1;
  logic [DATA_W-1:0] r_a1;
  logic [DATA_W-1:0] r_b1;
  logic              r_v2;
  logic [DATA_W-1:0] r_out;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_out;

  assign w_out = DATA_W'((({1'b0, r_a1} + BIAS) - {1'b0, r_b1}) >> 1);

  // Stage 1: capture the incoming pair and its valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_a1 <= '0;
      r_b1 <= '0;
    end else begin
      r_v1 <= bus.valid_in;
      r_a1 <= bus.a;
      r_b1 <= bus.b;
    end
  end

  // Stage 2: result register, holds its value through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_out <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) r_out <= w_out;
    end
  end

  // Accepted-pair counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (bus.valid_in) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.out        = r_out;
  assign bus.valid_out  = r_v2;
  assign bus.sample_cnt = r_cnt;

`ifdef HAAR_AVG_EN
  logic [DATA_W-1:0] r_avg;
  logic [DATA_W-1:0] w_avg;

  assign w_avg = DATA_W'(({1'b0, r_a1} + {1'b0, r_b1}) >> 1);

  // Approximation coefficient, pipelined identically to out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_avg <= '0;
    else if (r_v1) r_avg <= w_avg;
  end

  assign bus.avg = r_avg;
`endif

endmodule

// File: tb/tb_haar_diff.sv
// Self-checking bench for haar_diff: directed values plus random streams checked
// against an arithmetic reference model (queue of accepted pairs).
module tb_haar_diff;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 32;

  logic clk;
  logic rst_n;

  haar_diff_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  haar_diff #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int a;
    int b;
  } pair_t;

  pair_t q[$];
  bit    exp_v;
  int    exp_out;
  int    exp_avg;
  int    exp_cnt;
  int    n_checks;
  int    n_errors;

  // floor((a-b)/2) + 128 using plain integer arithmetic
  function automatic int ref_diff(input int a, input int b);
    int d;
    d = a - b;
    if (d >= 0) return d / 2 + 128;
    else        return -((1 - d) / 2) + 128;
  endfunction

  function automatic int ref_avg(input int a, input int b);
    return (a + b) / 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    exp_v   = 1'b0;
    exp_out = 0;
    exp_avg = 0;
    exp_cnt = 0;
  endtask

  task automatic check_model();
    check("valid_out", 32'(bus.valid_out), 32'(exp_v));
    check("out", 32'(bus.out), 32'(exp_out));
    check("sample_cnt", bus.sample_cnt, 32'(exp_cnt));
`ifdef HAAR_AVG_EN
    check("avg", 32'(bus.avg), 32'(exp_avg));
`endif
  endtask

  // One clock: drive a pair, advance the model, compare after the edge.
  task automatic cyc(input bit v, input int av, input int bv);
    pair_t p;
    bus.valid_in = v;
    bus.a        = DATA_W'(av);
    bus.b        = DATA_W'(bv);
    @(posedge clk);
    #1;
    p.v = v; p.a = av; p.b = bv;
    q.push_back(p);
    if (v) exp_cnt++;
    if (q.size() > 1) begin
      p = q.pop_front();
      exp_v = p.v;
      if (p.v) begin
        exp_out = ref_diff(p.a, p.b);
        exp_avg = ref_avg(p.a, p.b);
      end
    end
    check_model();
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 255));
  endfunction

  int da[7]   = '{200, 100, 37, 255, 0,   3,   4};
  int db[7]   = '{100, 200, 37, 0,   255, 4,   3};
  int dexp[7] = '{178, 78,  128, 255, 0,  127, 128};

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_model();
    rst_n        = 1'b0;
    bus.valid_in = 1'b1;
    bus.a        = 8'd0;
    bus.b        = 8'd0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      bus.valid_in = 1'($urandom_range(0, 1));
      bus.a        = DATA_W'(rnd());
      bus.b        = DATA_W'(rnd());
      @(posedge clk);
      #1;
      check("rst_out", 32'(bus.out), 32'd0);
      check("rst_valid", 32'(bus.valid_out), 32'd0);
      check("rst_cnt", bus.sample_cnt, 32'd0);
    end
    rst_n = 1'b1;

    // Basic and extreme values, back to back
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, da[i], db[i]);
      if (i == 0) check("first_latency", 32'(bus.valid_out), 32'd0);
      else        check("dir_out", 32'(bus.out), 32'(dexp[i-1]));
    end
    cyc(1'b0, rnd(), rnd());
    check("dir_out_last", 32'(bus.out), 32'(dexp[6]));
    check("dir_valid_last", 32'(bus.valid_out), 32'd1);

    // Bubble pattern 1,0,1
    cyc(1'b1, 10, 0);
    check("bub_v0", 32'(bus.valid_out), 32'd0);
    cyc(1'b0, rnd(), rnd());
    check("bub_out1", 32'(bus.out), 32'd133);
    check("bub_v1", 32'(bus.valid_out), 32'd1);
    cyc(1'b1, 0, 10);
    check("bub_hold", 32'(bus.out), 32'd133);
    check("bub_v2", 32'(bus.valid_out), 32'd0);
    cyc(1'b0, rnd(), rnd());
    check("bub_out3", 32'(bus.out), 32'd123);
    check("bub_v3", 32'(bus.valid_out), 32'd1);

`ifdef HAAR_AVG_EN
    cyc(1'b1, 255, 254);
    cyc(1'b1, 0, 1);
    check("avg_a", 32'(bus.avg), 32'd254);
    check("avg_a_out", 32'(bus.out), 32'd128);
    cyc(1'b0, rnd(), rnd());
    check("avg_b", 32'(bus.avg), 32'd0);
    check("avg_b_out", 32'(bus.out), 32'd127);
`endif

    // Random stream with random bubbles
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), rnd(), rnd());

    // Fresh reset, then exactly 1000 valid pairs
    #2 rst_n = 1'b0;
    #1 reset_model();
    check("rst2_cnt", bus.sample_cnt, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) cyc(1'b1, rnd(), rnd());
    check("cnt_1000", bus.sample_cnt, 32'd1000);

    // Mid-stream reset: everything drops at once, no stale output afterwards
    cyc(1'b1, rnd(), rnd());
    cyc(1'b1, rnd(), rnd());
    #1 rst_n = 1'b0;
    #1;
    check("mid_cnt", bus.sample_cnt, 32'd0);
    check("mid_valid", 32'(bus.valid_out), 32'd0);
    check("mid_out", 32'(bus.out), 32'd0);
    reset_model();
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    check("mid_hold_valid", 32'(bus.valid_out), 32'd0);
    #2 rst_n = 1'b1;
    cyc(1'b1, rnd(), rnd());
    check("post_rst_no_glitch", 32'(bus.valid_out), 32'd0);
    for (int i = 0; i < 30; i++)
      cyc(1'($urandom_range(0, 1)), rnd(), rnd());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
